// File: rtl/adder_share_rr_sched.sv
// adder_share_rr_sched: round-robin scheduler sharing one signed adder among NUM_REQ requesters.
// Optional saturation of LSB-selected results when ADDER_SHARE_SAT_EN is defined (adds sat_flag).
module adder_share_rr_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int TAKE_MSB       = 1,
  parameter int ID_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]  req_data_1,
  input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]  req_data_2,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [ID_WIDTH-1:0]               resp_id,
  output logic [DATA_OUT_WIDTH-1:0]         resp_data,
`ifdef ADDER_SHARE_SAT_EN
  output logic                              sat_flag,
`endif
  output logic                              busy
);
  localparam int SW = DATA_IN_WIDTH + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t                      state_q;
  logic [ID_WIDTH-1:0]         rr_ptr_q, resp_id_q, gnt, idx;
  logic [DATA_OUT_WIDTH-1:0]   resp_data_q, res_d;
  logic                        resp_valid_q, found, can_accept, xfer;
  logic [DATA_IN_WIDTH-1:0]    a, b;
  logic signed [SW-1:0]        sum;
  // Walk downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    found = 1'b0;
    gnt   = rr_ptr_q;
    idx   = rr_ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end
  assign can_accept = rst_n && (state_q == IDLE || resp_ready);
  assign xfer       = can_accept && found;
  assign req_ready  = xfer ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt) : '0;
  assign a          = req_data_1[gnt*DATA_IN_WIDTH +: DATA_IN_WIDTH];
  assign b          = req_data_2[gnt*DATA_IN_WIDTH +: DATA_IN_WIDTH];
  assign sum        = {a[DATA_IN_WIDTH-1], a} + {b[DATA_IN_WIDTH-1], b};
`ifdef ADDER_SHARE_SAT_EN
  logic sat_d, sat_q;
`endif
  generate
    if (TAKE_MSB != 0) begin : g_msb
      assign res_d = DATA_OUT_WIDTH'(sum >>> (SW - DATA_OUT_WIDTH));
`ifdef ADDER_SHARE_SAT_EN
      assign sat_d = 1'b0;
`endif
    end else begin : g_lsb
`ifdef ADDER_SHARE_SAT_EN
      logic fits;
      // The sum fits when every bit above the result's sign bit equals it.
      assign fits  = (&sum[SW-1:DATA_OUT_WIDTH-1]) || !(|sum[SW-1:DATA_OUT_WIDTH-1]);
      assign sat_d = !fits;
      assign res_d = fits ? sum[DATA_OUT_WIDTH-1:0]
                          : {sum[SW-1], {(DATA_OUT_WIDTH-1){~sum[SW-1]}}};
`else
      assign res_d = DATA_OUT_WIDTH'(sum);
`endif
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
`ifdef ADDER_SHARE_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else if (xfer) begin
      state_q      <= HOLD;
      rr_ptr_q     <= (gnt == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
      resp_valid_q <= 1'b1;
      resp_id_q    <= gnt;
      resp_data_q  <= res_d;
`ifdef ADDER_SHARE_SAT_EN
      sat_q        <= sat_d;
`endif
    end else if (state_q == HOLD && resp_ready) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
    end
  end
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q == HOLD);
`ifdef ADDER_SHARE_SAT_EN
  assign sat_flag   = sat_q;
`endif
endmodule
